// File: rtl/echo_heard_serializer.sv
// Buffers heard(meth, v) messages in a small FIFO and serializes each one onto
// a single word channel as two beats: meth first, then v flagged last.
module echo_heard_serializer #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                       CLK,
   input  logic                       nRST,
   input  logic                       indication_heard__ENA,
   input  logic [WIDTH-1:0]           indication_heard_meth,
   input  logic [WIDTH-1:0]           indication_heard_v,
   output logic                       indication_heard__RDY,
   output logic                       pipe_enq__ENA,
   output logic [WIDTH-1:0]           pipe_enq_v,
   output logic                       pipe_enq_last,
   input  logic                       pipe_enq__RDY,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // state    | meaning
   // PH_METH  | head entry (if any) is presented as its meth beat
   // PH_V     | meth beat already sent; head entry presented as its v beat
   // idle is not a phase of its own: it is simply count == 0
   typedef enum logic {
      PH_METH = 1'b0,
      PH_V    = 1'b1
   } phase_t;

   phase_t           phase_q, phase_d;
   logic [AW-1:0]    wp_q, wp_d;
   logic [AW-1:0]    rp_q, rp_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push, pop, busy;

   logic [WIDTH-1:0] meth_mem [DEPTH];
   logic [WIDTH-1:0] v_mem    [DEPTH];

   assign busy                  = (count_q != '0);
   assign indication_heard__RDY = (count_q != CW'(DEPTH));
   assign push                  = indication_heard__ENA && indication_heard__RDY;
   assign count                 = count_q;

   always_comb begin
      phase_d       = phase_q;
      rp_d          = rp_q;
      wp_d          = wp_q;
      count_d       = count_q;
      pop           = 1'b0;
      pipe_enq__ENA = busy && pipe_enq__RDY;
      pipe_enq_v    = '0;
      pipe_enq_last = 1'b0;

      if (busy) begin
         case (phase_q)
            PH_METH: begin
               pipe_enq_v = meth_mem[rp_q];
               if (pipe_enq__ENA) phase_d = PH_V;
            end
            PH_V: begin
               pipe_enq_v    = v_mem[rp_q];
               pipe_enq_last = 1'b1;
               if (pipe_enq__ENA) begin
                  phase_d = PH_METH;
                  pop     = 1'b1;
                  rp_d    = rp_q + AW'(1);
               end
            end
            default: phase_d = PH_METH;
         endcase
      end

      if (push) wp_d = wp_q + AW'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         phase_q <= PH_METH;
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
      end else begin
         phase_q <= phase_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
      end
   end

   // Payload storage carries no reset; count guards every read.
   always_ff @(posedge CLK) begin
      if (push) begin
         meth_mem[wp_q] <= indication_heard_meth;
         v_mem[wp_q]    <= indication_heard_v;
      end
   end

endmodule

// File: tb/tb_echo_heard_serializer.sv
// Self-checking bench for echo_heard_serializer: queue-based message model
// compared against the DUT every cycle, plus directed literal expectations.
module tb_echo_heard_serializer;

   localparam int DEPTH = 4;
   localparam int WIDTH = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             CLK;
   logic             nRST;
   logic             heard_ena;
   logic [WIDTH-1:0] heard_meth;
   logic [WIDTH-1:0] heard_v;
   logic             heard_rdy;
   logic             enq_ena;
   logic [WIDTH-1:0] enq_v;
   logic             enq_last;
   logic             enq_rdy;
   logic [CW-1:0]    count;

   echo_heard_serializer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .CLK                   (CLK),
      .nRST                  (nRST),
      .indication_heard__ENA (heard_ena),
      .indication_heard_meth (heard_meth),
      .indication_heard_v    (heard_v),
      .indication_heard__RDY (heard_rdy),
      .pipe_enq__ENA         (enq_ena),
      .pipe_enq_v            (enq_v),
      .pipe_enq_last         (enq_last),
      .pipe_enq__RDY         (enq_rdy),
      .count                 (count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [WIDTH-1:0] m;
      logic [WIDTH-1:0] v;
   } msg_t;

   msg_t mq[$];
   bit   mph;
   int   checks = 0;
   int   errors = 0;

   logic             s_ena, s_last, s_hrdy;
   logic [WIDTH-1:0] s_v;
   logic [CW-1:0]    s_cnt;
   bit               last_accept;

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive, compare against the model at negedge, advance the model at posedge.
   task automatic cycle(input bit e, input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] vv, input bit r);
      bit               rdy_e, ena_e, last_e;
      logic [WIDTH-1:0] v_e;
      heard_ena  = e;
      heard_meth = m;
      heard_v    = vv;
      enq_rdy    = r;
      @(negedge CLK);
      rdy_e  = (mq.size() != DEPTH);
      ena_e  = (mq.size() != 0) && r;
      v_e    = (mq.size() == 0) ? '0 : (mph ? mq[0].v : mq[0].m);
      last_e = (mq.size() != 0) && mph;
      s_ena = enq_ena; s_v = enq_v; s_last = enq_last; s_hrdy = heard_rdy; s_cnt = count;
      chk("heard_rdy", {31'd0, heard_rdy}, {31'd0, rdy_e});
      chk("enq_ena",   {31'd0, enq_ena},   {31'd0, ena_e});
      chk("enq_v",     enq_v,              v_e);
      chk("enq_last",  {31'd0, enq_last},  {31'd0, last_e});
      chk("count",     WIDTH'(count),      WIDTH'(mq.size()));
      @(posedge CLK);
      if (ena_e) begin
         if (mph) begin
            void'(mq.pop_front());
            mph = 1'b0;
         end else begin
            mph = 1'b1;
         end
      end
      last_accept = e && rdy_e;
      if (last_accept) mq.push_back('{m: m, v: vv});
      #1;
   endtask

   task automatic drain();
      int budget = 4 * DEPTH + 8;
      while (mq.size() != 0 && budget > 0) begin
         cycle(1'b0, '0, '0, 1'b1);
         budget--;
      end
      chk("drain_timeout", WIDTH'(mq.size()), '0);
   endtask

   initial begin
      int accepted;
      int budget;
      nRST = 1'b0; heard_ena = 1'b0; heard_meth = '0; heard_v = '0; enq_rdy = 1'b1;
      mph = 1'b0;
      #12;
      chk("rst_heard_rdy", {31'd0, heard_rdy}, 32'd1);
      chk("rst_enq_ena",   {31'd0, enq_ena},   32'd0);
      chk("rst_enq_v",     enq_v,              32'd0);
      chk("rst_count",     WIDTH'(count),      32'd0);
      @(posedge CLK); #1 nRST = 1'b1;

      // Single message latency and beat order.
      cycle(1'b1, 32'h10, 32'hAAAA, 1'b1);
      cycle(1'b0, '0, '0, 1'b1);
      chk("t1_meth_ena", {31'd0, s_ena}, 32'd1);
      chk("t1_meth_v",   s_v,            32'h10);
      chk("t1_meth_last",{31'd0, s_last},32'd0);
      cycle(1'b0, '0, '0, 1'b1);
      chk("t1_v_v",      s_v,            32'hAAAA);
      chk("t1_v_last",   {31'd0, s_last},32'd1);
      cycle(1'b0, '0, '0, 1'b1);
      chk("t1_idle_ena", {31'd0, s_ena}, 32'd0);
      chk("t1_idle_cnt", WIDTH'(s_cnt),  32'd0);

      // Fill while stalled, extra push ignored, then drain.
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h100 + i, 32'h200 + i, 1'b0);
      cycle(1'b1, 32'hDEAD, 32'hBEEF, 1'b0);
      chk("t2_full_cnt", WIDTH'(s_cnt),  DEPTH);
      chk("t2_full_rdy", {31'd0, s_hrdy},32'd0);
      chk("t2_5th_drop", {31'd0, last_accept}, 32'd0);
      drain();

      // Downstream ready toggling every cycle.
      cycle(1'b1, 32'h31, 32'h41, 1'b0);
      cycle(1'b1, 32'h32, 32'h42, 1'b1);
      for (int i = 0; i < 12; i++) cycle(1'b0, '0, '0, i[0]);
      drain();

      // Continuous pushes across pointer wrap.
      accepted = 0;
      budget   = 100;
      while (accepted < 2 * DEPTH + 3 && budget > 0) begin
         cycle(1'b1, WIDTH'(accepted), ~WIDTH'(accepted), 1'b1);
         chk("t4_cnt_le_depth", {31'd0, s_cnt <= CW'(DEPTH)}, 32'd1);
         if (last_accept) accepted++;
         budget--;
      end
      chk("t4_all_accepted", accepted, 2 * DEPTH + 3);
      drain();

      // Push coinciding with a V-beat pop at count 2.
      cycle(1'b1, 32'h51, 32'h61, 1'b0);
      cycle(1'b1, 32'h52, 32'h62, 1'b0);
      cycle(1'b0, '0, '0, 1'b1);
      cycle(1'b1, 32'h53, 32'h63, 1'b1);
      chk("t5_pre_cnt", WIDTH'(s_cnt), 32'd2);
      chk("t5_pop_last", {31'd0, s_last}, 32'd1);
      cycle(1'b0, '0, '0, 1'b1);
      chk("t5_post_cnt", WIDTH'(s_cnt), 32'd2);
      chk("t5_next_head", s_v, 32'h52);
      drain();

      // Randomized traffic.
      for (int i = 0; i < 400; i++)
         cycle(($urandom_range(0, 2) != 0), $urandom, $urandom, ($urandom_range(0, 3) != 0));
      drain();

      // Asynchronous reset between meth and v beats.
      cycle(1'b1, 32'h77, 32'h88, 1'b1);
      cycle(1'b0, '0, '0, 1'b1);
      chk("t6_meth_sent", s_v, 32'h77);
      #2 nRST = 1'b0;
      #1;
      chk("t6_rst_hrdy", {31'd0, heard_rdy}, 32'd1);
      chk("t6_rst_ena",  {31'd0, enq_ena},   32'd0);
      chk("t6_rst_last", {31'd0, enq_last},  32'd0);
      chk("t6_rst_v",    enq_v,              32'd0);
      chk("t6_rst_cnt",  WIDTH'(count),      32'd0);
      mq.delete();
      mph = 1'b0;
      @(posedge CLK); #1 nRST = 1'b1;
      cycle(1'b1, 32'h5, 32'h6, 1'b1);
      cycle(1'b0, '0, '0, 1'b1);
      chk("t6_after_v",    s_v,            32'h5);
      chk("t6_after_last", {31'd0, s_last},32'd0);
      chk("t6_after_ena",  {31'd0, s_ena}, 32'd1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
